// File: rtl/vga_pmod_capture.sv
// Capture side of the TinyVGA PMOD link: recovers syncs and RGB, rebuilds pixel
// coordinates from sync edges, tracks line/frame timing lock and the per-frame lit-pixel box.
module vga_pmod_capture #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_START     = 49,
  parameter int V_START     = 32,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pmod_in,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        locked,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic        frame_done,
  output logic        bbox_valid,
  output logic [9:0]  bbox_x0,
  output logic [9:0]  bbox_y0,
  output logic [9:0]  bbox_x1,
  output logic [9:0]  bbox_y1
);

  localparam logic [10:0] H_LO      = 11'(H_START);
  localparam logic [10:0] H_HI      = 11'(H_START + H_ACTIVE - 1);
  localparam logic [10:0] H_TOT     = 11'(H_TOTAL);
  localparam logic [9:0]  V_LO      = 10'(V_START);
  localparam logic [9:0]  V_HI      = 10'(V_START + V_ACTIVE - 1);
  localparam logic [9:0]  V_TOT     = 10'(V_TOTAL);
  localparam logic [3:0]  LOCK_LAST = 4'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} lock_state_t;

  logic        hs, vs, hs_prev, vs_prev;
  logic        hs_rise, vs_rise, vs_fall;
  logic [5:0]  rgb;
  logic [10:0] hcnt, hcnt_cur, len_meas;
  logic [9:0]  lcnt, lcnt_cur, lines_meas;
  logic        hs_seen, vs_seen, vs_pend, edge0;
  logic        in_win, lit;
  logic [9:0]  x_cur, y_cur;
  logic [9:0]  run_x0, run_y0, run_x1, run_y1;
  logic        run_seen;
  logic        frame_match, line_bad;
  lock_state_t state, state_next;
  logic [3:0]  fcnt, fcnt_next;

  assign hs      = pmod_in[7];
  assign vs      = pmod_in[3];
  assign rgb     = {pmod_in[0], pmod_in[4], pmod_in[1], pmod_in[5], pmod_in[2], pmod_in[6]};
  assign hs_rise = hs & ~hs_prev;
  assign vs_rise = vs & ~vs_prev;
  assign vs_fall = ~vs & vs_prev;

  // Edge index 0 is the first hsync rise at or after the vsync rise.
  assign edge0      = hs_rise & (vs_pend | vs_rise);
  assign len_meas   = (hcnt == 11'h7FF) ? 11'h7FF : hcnt + 11'd1;
  assign lines_meas = (lcnt == 10'h3FF) ? 10'h3FF : lcnt + 10'd1;
  assign hcnt_cur   = hs_rise ? 11'd0 : len_meas;
  assign lcnt_cur   = hs_rise ? (edge0 ? 10'd0 : lines_meas) : lcnt;

  assign in_win = (vs_seen | vs_rise) &&
                  (hcnt_cur >= H_LO) && (hcnt_cur <= H_HI) &&
                  (lcnt_cur >= V_LO) && (lcnt_cur <= V_HI);
  assign x_cur  = hcnt_cur[9:0] - H_LO[9:0];
  assign y_cur  = lcnt_cur - V_LO;
  assign lit    = in_win && (rgb != 6'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_prev     <= 1'b1;
      vs_prev     <= 1'b1;
      hcnt        <= '0;
      lcnt        <= '0;
      hs_seen     <= 1'b0;
      vs_seen     <= 1'b0;
      vs_pend     <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
    end else begin
      hs_prev <= hs;
      vs_prev <= vs;
      hcnt    <= hcnt_cur;
      lcnt    <= lcnt_cur;
      if (hs_rise) begin
        hs_seen <= 1'b1;
        if (hs_seen) line_len <= len_meas;
      end
      if (vs_rise) begin
        vs_seen <= 1'b1;
        if (vs_seen) frame_lines <= lines_meas;
      end
      if (hs_rise)      vs_pend <= 1'b0;
      else if (vs_rise) vs_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_rgb   <= '0;
    end else begin
      pix_valid <= in_win;
      pix_x     <= in_win ? x_cur : 10'd0;
      pix_y     <= in_win ? y_cur : 10'd0;
      pix_rgb   <= in_win ? rgb : 6'd0;
    end
  end

  // line_len is still the previous value here, i.e. the last completed line.
  assign frame_match = (line_len == H_TOT) && (lines_meas == V_TOT);
  assign line_bad    = hs_rise && hs_seen && (len_meas != H_TOT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEARCH;
      fcnt  <= '0;
    end else begin
      state <= state_next;
      fcnt  <= fcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    fcnt_next  = fcnt;
    case (state)
      SEARCH: begin
        if (vs_rise) begin
          state_next = TRACK;
          fcnt_next  = '0;
        end
      end
      TRACK: begin
        if (vs_rise) begin
          if (frame_match) begin
            fcnt_next = fcnt + 4'd1;
            if (fcnt >= LOCK_LAST) state_next = LOCKED;
          end else begin
            fcnt_next = '0;
          end
        end
      end
      LOCKED: begin
        if (line_bad || (vs_rise && !frame_match)) begin
          state_next = TRACK;
          fcnt_next  = '0;
        end
      end
      default: begin
        state_next = SEARCH;
        fcnt_next  = '0;
      end
    endcase
  end

  assign locked = (state == LOCKED);

  // Publishing wins over a coincident lit pixel; that pixel is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_x0     <= 10'h3FF;
      run_y0     <= 10'h3FF;
      run_x1     <= '0;
      run_y1     <= '0;
      run_seen   <= 1'b0;
      frame_done <= 1'b0;
      bbox_valid <= 1'b0;
      bbox_x0    <= '0;
      bbox_y0    <= '0;
      bbox_x1    <= '0;
      bbox_y1    <= '0;
    end else if (vs_fall) begin
      frame_done <= 1'b1;
      bbox_valid <= run_seen;
      bbox_x0    <= run_seen ? run_x0 : 10'd0;
      bbox_y0    <= run_seen ? run_y0 : 10'd0;
      bbox_x1    <= run_seen ? run_x1 : 10'd0;
      bbox_y1    <= run_seen ? run_y1 : 10'd0;
      run_x0     <= 10'h3FF;
      run_y0     <= 10'h3FF;
      run_x1     <= '0;
      run_y1     <= '0;
      run_seen   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (lit) begin
        run_seen <= 1'b1;
        if (x_cur < run_x0) run_x0 <= x_cur;
        if (y_cur < run_y0) run_y0 <= y_cur;
        if (x_cur > run_x1) run_x1 <= x_cur;
        if (y_cur > run_y1) run_y1 <= y_cur;
      end
    end
  end

endmodule

// File: tb/tb_vga_pmod_capture.sv
// Bench for vga_pmod_capture on a shrunken 32x20 video raster: a timestamp/count
// reference model predicts every output each cycle, plus directed lock and bbox checks.
module tb_vga_pmod_capture;

  localparam int HT   = 32;
  localparam int HA   = 16;
  localparam int HS0  = 20;
  localparam int HS1  = 24;
  localparam int VT   = 20;
  localparam int VA   = 12;
  localparam int VS0  = 14;
  localparam int VS1  = 16;
  localparam int HSTA = HT - HS1 + 1;
  localparam int VSTA = VT - VS1 - 1;
  localparam int LOCKN = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pmod_in;
  logic        pix_valid, locked, frame_done, bbox_valid;
  logic [9:0]  pix_x, pix_y, frame_lines, bbox_x0, bbox_y0, bbox_x1, bbox_y1;
  logic [5:0]  pix_rgb;
  logic [10:0] line_len;

  always #5 clk = ~clk;

  vga_pmod_capture #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .H_START(HSTA), .V_START(VSTA), .LOCK_FRAMES(LOCKN)
  ) dut (
    .clk(clk), .reset(reset), .pmod_in(pmod_in),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .locked(locked), .line_len(line_len), .frame_lines(frame_lines),
    .frame_done(frame_done), .bbox_valid(bbox_valid),
    .bbox_x0(bbox_x0), .bbox_y0(bbox_y0), .bbox_x1(bbox_x1), .bbox_y1(bbox_y1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: sample index, edge timestamps and edge counts.
  int m_t, m_last_hrise, m_nh, m_base, m_consec;
  bit m_hs_prev, m_vs_prev, m_any_hrise, m_vpend, m_vseen, m_locked;
  bit m_run_seen;
  int m_min_x, m_min_y, m_max_x, m_max_y;
  int e_pix_valid, e_x, e_y, e_rgb, e_line_len, e_frame_lines, e_frame_done;
  int e_bbox_valid, e_bx0, e_by0, e_bx1, e_by1;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic void model_reset();
    m_t = 0; m_last_hrise = -1; m_nh = 0; m_base = 0; m_consec = 0;
    m_hs_prev = 1'b1; m_vs_prev = 1'b1; m_any_hrise = 1'b0; m_vpend = 1'b0;
    m_vseen = 1'b0; m_locked = 1'b0;
    m_run_seen = 1'b0; m_min_x = 1023; m_min_y = 1023; m_max_x = 0; m_max_y = 0;
    e_pix_valid = 0; e_x = 0; e_y = 0; e_rgb = 0; e_line_len = 0; e_frame_lines = 0;
    e_frame_done = 0; e_bbox_valid = 0; e_bx0 = 0; e_by0 = 0; e_bx1 = 0; e_by1 = 0;
  endfunction

  function automatic void model_sample(input bit hs, input bit vs, input logic [5:0] rgb);
    bit hr, vr, vf, match, bad, win;
    int lc_prev, len, hc, lc;
    hr = hs && !m_hs_prev;
    vr = vs && !m_vs_prev;
    vf = !vs && m_vs_prev;
    lc_prev = sat(m_nh - m_base, 1023);
    len = sat(m_t - m_last_hrise, 2047);
    match = (e_line_len == HT) && (sat(lc_prev + 1, 1023) == VT);
    bad = hr && m_any_hrise && (len != HT);
    if (m_locked) begin
      if (bad || (vr && !match)) begin
        m_locked = 1'b0;
        m_consec = 0;
      end
    end else if (vr && m_vseen) begin
      if (match) begin
        m_consec++;
        if (m_consec >= LOCKN) m_locked = 1'b1;
      end else begin
        m_consec = 0;
      end
    end
    hc = hr ? 0 : len;
    if (hr) begin
      if (m_any_hrise) e_line_len = len;
      m_any_hrise = 1'b1;
      m_last_hrise = m_t;
      m_nh++;
      if (m_vpend || vr) begin
        m_base = m_nh;
        m_vpend = 1'b0;
      end
    end else if (vr) begin
      m_vpend = 1'b1;
    end
    if (vr) begin
      if (m_vseen) e_frame_lines = sat(lc_prev + 1, 1023);
      m_vseen = 1'b1;
    end
    lc = sat(m_nh - m_base, 1023);
    win = m_vseen && hc >= HSTA && hc <= HSTA + HA - 1 && lc >= VSTA && lc <= VSTA + VA - 1;
    e_pix_valid = win ? 1 : 0;
    e_x   = win ? hc - HSTA : 0;
    e_y   = win ? lc - VSTA : 0;
    e_rgb = win ? int'(rgb) : 0;
    if (vf) begin
      e_frame_done = 1;
      e_bbox_valid = m_run_seen ? 1 : 0;
      e_bx0 = m_run_seen ? m_min_x : 0;
      e_by0 = m_run_seen ? m_min_y : 0;
      e_bx1 = m_run_seen ? m_max_x : 0;
      e_by1 = m_run_seen ? m_max_y : 0;
      m_run_seen = 1'b0; m_min_x = 1023; m_min_y = 1023; m_max_x = 0; m_max_y = 0;
    end else begin
      e_frame_done = 0;
      if (win && rgb != 6'd0) begin
        m_run_seen = 1'b1;
        if (e_x < m_min_x) m_min_x = e_x;
        if (e_y < m_min_y) m_min_y = e_y;
        if (e_x > m_max_x) m_max_x = e_x;
        if (e_y > m_max_y) m_max_y = e_y;
      end
    end
    m_hs_prev = hs;
    m_vs_prev = vs;
    m_t++;
  endfunction

  task automatic check_all();
    check("pix_valid",   64'(pix_valid),   64'(e_pix_valid));
    check("pix_x",       64'(pix_x),       64'(e_x));
    check("pix_y",       64'(pix_y),       64'(e_y));
    check("pix_rgb",     64'(pix_rgb),     64'(e_rgb));
    check("locked",      64'(locked),      64'(m_locked));
    check("line_len",    64'(line_len),    64'(e_line_len));
    check("frame_lines", 64'(frame_lines), 64'(e_frame_lines));
    check("frame_done",  64'(frame_done),  64'(e_frame_done));
    check("bbox", 64'({bbox_valid, bbox_x0, bbox_y0, bbox_x1, bbox_y1}),
          64'({1'(e_bbox_valid), 10'(e_bx0), 10'(e_by0), 10'(e_bx1), 10'(e_by1)}));
  endtask

  // Drives one sample at the falling edge, then checks the registered result.
  task automatic step(input bit hs, input bit vs, input logic [5:0] rgb, input bit rst);
    reset   = rst;
    pmod_in = {hs, rgb[0], rgb[2], rgb[4], vs, rgb[1], rgb[3], rgb[5]};
    if (rst) model_reset();
    else model_sample(hs, vs, rgb);
    @(negedge clk);
    check_all();
  endtask

  logic [5:0] fb [VA][HA];
  logic [5:0] rgb_d;

  task automatic clear_fb();
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++) fb[y][x] = 6'd0;
  endtask

  task automatic send_line(input int v, input int extra, input int rst_h);
    bit hs, vs, rst;
    logic [5:0] src;
    for (int h = 0; h < HT + extra; h++) begin
      hs  = !(h >= HS0 && h < HS1);
      vs  = !(v >= VS0 && v < VS1);
      src = (h < HA && v < VA) ? fb[v][h] : 6'd0;
      rst = (rst_h >= 0) && (h >= rst_h) && (h < rst_h + 3);
      step(hs, vs, rgb_d, rst);
      rgb_d = src;
    end
  endtask

  task automatic send_frame(input int bad_v, input int extra, input int rst_v, input int rst_h);
    for (int v = 0; v < VT; v++)
      send_line(v, (v == bad_v) ? extra : 0, (v == rst_v) ? rst_h : -1);
  endtask

  task automatic random_pattern();
    int kind, bx, by, bw, bh, n;
    clear_fb();
    kind = $urandom_range(0, 3);
    if (kind == 1) begin
      bx = $urandom_range(0, HA - 1); by = $urandom_range(0, VA - 1);
      bw = $urandom_range(1, HA - bx); bh = $urandom_range(1, VA - by);
      for (int y = by; y < by + bh; y++)
        for (int x = bx; x < bx + bw; x++) fb[y][x] = 6'($urandom_range(1, 63));
    end else if (kind >= 2) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++)
        fb[$urandom_range(0, VA - 1)][$urandom_range(0, HA - 1)] = 6'($urandom_range(1, 63));
    end
  endtask

  initial begin
    int bx, by, bw, bh;
    reset   = 1'b1;
    pmod_in = 8'hFF;
    rgb_d   = 6'd0;
    model_reset();
    clear_fb();
    @(negedge clk);
    repeat (3) step(1'b1, 1'b1, 6'd0, 1'b1);
    check("rst_pix_valid", 64'(pix_valid), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_line_len", 64'(line_len), 64'd0);

    send_frame(-1, 0, -1, 0);

    fb[0][0] = 6'($urandom_range(1, 63));
    fb[VA-1][HA-1] = 6'($urandom_range(1, 63));
    send_frame(-1, 0, -1, 0);
    check("corner_bbox", 64'({bbox_valid, bbox_x0, bbox_y0, bbox_x1, bbox_y1}),
          64'({1'b1, 10'd0, 10'd0, 10'(HA - 1), 10'(VA - 1)}));
    check("pre_lock", 64'(locked), 64'd0);

    clear_fb();
    bx = $urandom_range(0, HA - 1); by = $urandom_range(0, VA - 1);
    bw = $urandom_range(1, HA - bx); bh = $urandom_range(1, VA - by);
    for (int y = by; y < by + bh; y++)
      for (int x = bx; x < bx + bw; x++) fb[y][x] = 6'h3F;
    send_frame(-1, 0, -1, 0);
    check("block_bbox", 64'({bbox_valid, bbox_x0, bbox_y0, bbox_x1, bbox_y1}),
          64'({1'b1, 10'(bx), 10'(by), 10'(bx + bw - 1), 10'(by + bh - 1)}));
    check("lock_3rd_vrise", 64'(locked), 64'd1);
    check("meas_line_len", 64'(line_len), 64'(HT));
    check("meas_frame_lines", 64'(frame_lines), 64'(VT));

    clear_fb();
    send_frame(-1, 0, -1, 0);
    check("black_bbox", 64'({bbox_valid, bbox_x0, bbox_y0, bbox_x1, bbox_y1}), 64'd0);

    random_pattern();
    send_frame(5, 1, -1, 0);
    check("bad_line_unlock", 64'(locked), 64'd0);
    random_pattern();
    send_frame(-1, 0, -1, 0);
    check("relock", 64'(locked), 64'd1);

    random_pattern();
    send_frame(-1, 0, 7, 10);
    check("post_reset_unlocked", 64'(locked), 64'd0);
    send_frame(-1, 0, -1, 0);
    check("reacq_pending", 64'(locked), 64'd0);
    send_frame(-1, 0, -1, 0);
    check("reacq_locked", 64'(locked), 64'd1);

    for (int i = 0; i < 2999; i++) step(1'b0, 1'b1, 6'd0, 1'b0);
    step(1'b1, 1'b1, 6'd0, 1'b0);
    check("sat_line_len", 64'(line_len), 64'd2047);
    check("sat_unlock", 64'(locked), 64'd0);
    rgb_d = 6'd0;

    for (int i = 0; i < 14; i++) begin
      random_pattern();
      if ($urandom_range(0, 3) == 0) send_frame($urandom_range(0, VT - 1), $urandom_range(1, 3), -1, 0);
      else send_frame(-1, 0, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
